// File: rtl/up_seq_pkg.sv
// Shared encodings for the micro-sequencer: FSM states, opcode values and ALU selects.
package up_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_CMP  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_NAND = 3'b100;

    // Opcodes whose operand comes from RAM (RAM drives the bus).
    function automatic logic is_mem_read(input logic [3:0] op);
        return (op == OP_CMPM) || (op == OP_LD) || (op == OP_ADDM) || (op == OP_NANDM);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return is_mem_read(op) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/up_seq_decode.sv
// Combinational decode of sequencer state, opcode and flags into datapath control strobes.
module up_seq_decode
    import up_seq_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  instr,
    input  logic        c_flag,
    input  logic        z_flag,
    output logic        phase,
    output logic        fetch_en,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [2:0]  alu_sel,
    output logic        accu_en,
    output logic        flags_en,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        in_oe,
    output logic        out_en,
    output logic        halted
);

    always_comb begin
        phase    = 1'b0;
        fetch_en = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_sel  = ALU_NONE;
        accu_en  = 1'b0;
        flags_en = 1'b0;
        ram_oe   = 1'b0;
        ram_we   = 1'b0;
        in_oe    = 1'b0;
        out_en   = 1'b0;
        halted   = 1'b0;

        case (state)
            ST_IDLE: begin
                halted = 1'b1;
            end
            ST_FETCH: begin
                fetch_en = 1'b1;
                pc_inc   = 1'b1;
            end
            ST_WAIT: begin
                phase  = 1'b1;
                ram_oe = is_mem_read(instr);
            end
            ST_EXEC: begin
                phase  = 1'b1;
                ram_oe = is_mem_read(instr);
                case (instr)
                    OP_JC:    pc_load = c_flag;
                    OP_JNC:   pc_load = ~c_flag;
                    OP_JZ:    pc_load = z_flag;
                    OP_JNZ:   pc_load = ~z_flag;
                    OP_JMP:   pc_load = 1'b1;
                    OP_CMPI, OP_CMPM: begin
                        flags_en = 1'b1;
                        alu_sel  = ALU_CMP;
                    end
                    OP_LIT, OP_LD: begin
                        accu_en = 1'b1;
                        alu_sel = ALU_PASS;
                    end
                    OP_IN: begin
                        accu_en = 1'b1;
                        alu_sel = ALU_PASS;
                        in_oe   = 1'b1;
                    end
                    OP_ADDI, OP_ADDM: begin
                        accu_en  = 1'b1;
                        flags_en = 1'b1;
                        alu_sel  = ALU_ADD;
                    end
                    OP_NANDI, OP_NANDM: begin
                        accu_en  = 1'b1;
                        flags_en = 1'b1;
                        alu_sel  = ALU_NAND;
                    end
                    OP_ST:    ram_we = 1'b1;
                    OP_OUT:   out_en = 1'b1;
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/up_sequencer.sv
// Four-state fetch/execute sequencer; only the state is registered, all strobes are decoded.
// Define UP_SEQ_RAM_WAIT_EN to insert a WAIT cycle for RAM-accessing opcodes.
module up_sequencer
    import up_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  instr,
    input  logic        c_flag,
    input  logic        z_flag,
    output logic        phase,
    output logic        fetch_en,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [2:0]  alu_sel,
    output logic        accu_en,
    output logic        flags_en,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        in_oe,
    output logic        out_en,
    output logic        halted
);

    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
`ifdef UP_SEQ_RAM_WAIT_EN
                // The fetch latch is transparent while fetch_en is high, so the
                // incoming opcode is already visible for the wait-state decision.
                state_d = is_mem_op(instr) ? ST_WAIT : ST_EXEC;
`else
                state_d = ST_EXEC;
`endif
            end
            ST_WAIT:  state_d = ST_EXEC;
            ST_EXEC:  state_d = run ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    up_seq_decode u_decode (
        .state    (state_q),
        .instr    (instr),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .phase    (phase),
        .fetch_en (fetch_en),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .alu_sel  (alu_sel),
        .accu_en  (accu_en),
        .flags_en (flags_en),
        .ram_oe   (ram_oe),
        .ram_we   (ram_we),
        .in_oe    (in_oe),
        .out_en   (out_en),
        .halted   (halted)
    );

endmodule

// File: tb/tb_up_sequencer.sv
// Directed, table-driven bench for up_sequencer; follows UP_SEQ_RAM_WAIT_EN if defined.
module tb_up_sequencer;

    logic       clock;
    logic       reset;
    logic       run;
    logic [3:0] instr;
    logic       c_flag;
    logic       z_flag;
    logic       phase;
    logic       fetch_en;
    logic       pc_inc;
    logic       pc_load;
    logic [2:0] alu_sel;
    logic       accu_en;
    logic       flags_en;
    logic       ram_oe;
    logic       ram_we;
    logic       in_oe;
    logic       out_en;
    logic       halted;

    int pass_cnt;
    int total_cnt;

    up_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .instr    (instr),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .phase    (phase),
        .fetch_en (fetch_en),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .alu_sel  (alu_sel),
        .accu_en  (accu_en),
        .flags_en (flags_en),
        .ram_oe   (ram_oe),
        .ram_we   (ram_we),
        .in_oe    (in_oe),
        .out_en   (out_en),
        .halted   (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output word: {phase, fetch_en, pc_inc, pc_load, alu_sel, accu_en,
    //               flags_en, ram_oe, ram_we, in_oe, out_en, halted}
    logic [13:0] outs;
    assign outs = {phase, fetch_en, pc_inc, pc_load, alu_sel, accu_en,
                   flags_en, ram_oe, ram_we, in_oe, out_en, halted};

    localparam logic [13:0] W_IDLE  = 14'b0_0_0_0_000_000000_1;
    localparam logic [13:0] W_FETCH = 14'b0_1_1_0_000_000000_0;

    // ex = {pc_load, alu_sel, accu_en, flags_en, ram_oe, ram_we, in_oe, out_en}
    function automatic logic [13:0] w_exec(input logic [9:0] ex);
        return {1'b1, 1'b0, 1'b0, ex, 1'b0};
    endfunction

    function automatic logic [13:0] w_wait(input logic oe);
        return {1'b1, 1'b0, 1'b0, 6'b0, oe, 3'b0, 1'b0};
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == 4'h3) || (op == 4'h6) || (op == 4'h7) || (op == 4'hB) || (op == 4'hF);
    endfunction

    function automatic logic is_rd(input logic [3:0] op);
        return (op == 4'h3) || (op == 4'h6) || (op == 4'hB) || (op == 4'hF);
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] op;
        logic       c;
        logic       z;
        logic [9:0] ex;
    } vec_t;

    vec_t vecs[22];
    int   cycles;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset  = 1'b1;
        run    = 1'b0;
        instr  = 4'h0;
        c_flag = 1'b0;
        z_flag = 1'b0;

        vecs[0]  = '{4'h0, 1'b1, 1'b0, 10'b1_000_000000};
        vecs[1]  = '{4'h0, 1'b0, 1'b1, 10'b0_000_000000};
        vecs[2]  = '{4'h1, 1'b0, 1'b0, 10'b1_000_000000};
        vecs[3]  = '{4'h1, 1'b1, 1'b0, 10'b0_000_000000};
        vecs[4]  = '{4'h2, 1'b0, 1'b0, 10'b0_001_010000};
        vecs[5]  = '{4'h3, 1'b0, 1'b0, 10'b0_001_011000};
        vecs[6]  = '{4'h4, 1'b0, 1'b0, 10'b0_010_100000};
        vecs[7]  = '{4'h5, 1'b0, 1'b0, 10'b0_010_100010};
        vecs[8]  = '{4'h6, 1'b0, 1'b0, 10'b0_010_101000};
        vecs[9]  = '{4'h7, 1'b0, 1'b0, 10'b0_000_000100};
        vecs[10] = '{4'h8, 1'b0, 1'b1, 10'b1_000_000000};
        vecs[11] = '{4'h8, 1'b1, 1'b0, 10'b0_000_000000};
        vecs[12] = '{4'h9, 1'b0, 1'b0, 10'b1_000_000000};
        vecs[13] = '{4'h9, 1'b0, 1'b1, 10'b0_000_000000};
        vecs[14] = '{4'hA, 1'b0, 1'b0, 10'b0_011_110000};
        vecs[15] = '{4'hB, 1'b0, 1'b0, 10'b0_011_111000};
        vecs[16] = '{4'hC, 1'b0, 1'b0, 10'b1_000_000000};
        vecs[17] = '{4'hC, 1'b1, 1'b1, 10'b1_000_000000};
        vecs[18] = '{4'hD, 1'b0, 1'b0, 10'b0_000_000001};
        vecs[19] = '{4'hE, 1'b0, 1'b0, 10'b0_100_110000};
        vecs[20] = '{4'hF, 1'b0, 1'b0, 10'b0_100_111000};
        vecs[21] = '{4'h5, 1'b1, 1'b1, 10'b0_010_100010};

        // Reset state
        step();
        check("reset_idle", outs, W_IDLE);
        reset = 1'b0;
        step();
        check("idle_hold", outs, W_IDLE);

        // Table sweep: one instruction each, run dropped after fetch
        for (int i = 0; i < 22; i++) begin
            do_reset();
            instr  = vecs[i].op;
            c_flag = vecs[i].c;
            z_flag = vecs[i].z;
            run    = 1'b1;
            step();
            check($sformatf("fetch_op%h", vecs[i].op), outs, W_FETCH);
            run = 1'b0;
            step();
`ifdef UP_SEQ_RAM_WAIT_EN
            if (is_mem(vecs[i].op)) begin
                check($sformatf("wait_op%h", vecs[i].op), outs, w_wait(is_rd(vecs[i].op)));
                step();
            end
`endif
            check($sformatf("exec_op%h_c%0d_z%0d", vecs[i].op, vecs[i].c, vecs[i].z),
                  outs, w_exec(vecs[i].ex));
            check($sformatf("excl_op%h", vecs[i].op),
                  14'(int'(ram_oe) + int'(in_oe) + int'(ram_we) <= 1), 14'd1);
            check($sformatf("in_oe_op%h", vecs[i].op), 14'(in_oe), 14'(vecs[i].op == 4'h5));
            step();
            check($sformatf("after_op%h", vecs[i].op), outs, W_IDLE);
        end

        // LIT with run held: FETCH, EXEC, FETCH
        do_reset();
        instr = 4'h4; c_flag = 1'b0; z_flag = 1'b0; run = 1'b1;
        step();
        check("lit_fetch", outs, W_FETCH);
        step();
        check("lit_exec", outs, w_exec(10'b0_010_100000));
        step();
        check("lit_refetch", outs, W_FETCH);

        // JC not taken, next fetch follows
        do_reset();
        instr = 4'h0; c_flag = 1'b0; run = 1'b1;
        step();
        check("jc_fetch", outs, W_FETCH);
        step();
        check("jc_nt_exec", outs, w_exec(10'b0));
        step();
        check("jc_nt_refetch", outs, W_FETCH);

        // ST instruction length, fetch to next fetch
        do_reset();
        instr = 4'h7; run = 1'b1;
        step();
        check("st_fetch", outs, W_FETCH);
        cycles = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (!phase) break;
            cycles++;
        end
`ifdef UP_SEQ_RAM_WAIT_EN
        check("st_cycles", 14'(cycles), 14'd3);
`else
        check("st_cycles", 14'(cycles), 14'd2);
`endif
        check("st_then_fetch", outs, W_FETCH);

        // ADDM with run dropped during EXEC
        do_reset();
        instr = 4'hB; run = 1'b1;
        step();
        check("addm_fetch", outs, W_FETCH);
        step();
`ifdef UP_SEQ_RAM_WAIT_EN
        check("addm_wait", outs, w_wait(1'b1));
        step();
`endif
        run = 1'b0;
        check("addm_exec", outs, w_exec(10'b0_011_111000));
        step();
        check("addm_idle", outs, W_IDLE);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("addm_nofetch%0d", k), 14'(fetch_en), 14'd0);
        end

        // LD aborted by reset before any accumulator load
        do_reset();
        instr = 4'h6; run = 1'b1;
        step();
        check("ld_fetch", outs, W_FETCH);
`ifdef UP_SEQ_RAM_WAIT_EN
        step();
        check("ld_wait", outs, w_wait(1'b1));
`endif
        reset = 1'b1;
        step();
        check("ld_abort_idle", outs, W_IDLE);
        reset = 1'b0;
        run   = 1'b0;
        step();
        check("ld_abort_stay", outs, W_IDLE);
        check("ld_abort_no_accu", 14'(accu_en), 14'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
